// File: rtl/branch_resolve_ctrl.sv
// Purpose: sequences the shared branch comparator, checks its result against the fetch prediction, and on a mispredict issues a redirect plus a timed flush.
// Latency: accept edge -> 1 CMP cycle -> resolve pulse. A mispredict then holds flush for FLUSH_CYCLES cycles, starting in the redirect cycle.
// Backpressure: req_ready is high only in IDLE. A request presented while busy is ignored and must be held by the requester.
module branch_resolve_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [2:0]       req_funct3,
  input  logic             req_jump,
  input  logic             req_brun,
  input  logic             req_pred_taken,
  input  logic [XLEN-1:0]  req_pc,
  input  logic [XLEN-1:0]  req_target,
  output logic [XLEN-1:0]  cmp_a,
  output logic [XLEN-1:0]  cmp_b,
  output logic [2:0]       cmp_funct3,
  output logic             cmp_jump,
  output logic             cmp_brun,
  input  logic             cmp_taken,
  output logic             resolve_valid,
  output logic             resolve_taken,
  output logic             resolve_mispredict,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_REDIR, S_FLUSH} state_t;

  // The FLUSH state covers the flush cycles that remain after REDIR.
  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

  state_t          state, state_nxt;
  logic [FC_W-1:0] flush_cnt;
  logic [XLEN-1:0] pc_q, target_q;
  logic            pred_q;
  logic            accept;
  logic            mispredict;

  assign accept     = req_valid && (state == S_IDLE);
  assign mispredict = cmp_taken ^ pred_q;

  // State register and flush down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_REDIR)
        flush_cnt <= FC_LOAD;
      else if (state == S_FLUSH && flush_cnt != '0)
        flush_cnt <= flush_cnt - FC_W'(1);
    end
  end

  // Next-state logic and state-decoded handshake/flush outputs.
  always_comb begin
    state_nxt      = state;
    req_ready      = 1'b0;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nxt = S_CMP;
      end
      S_CMP: begin
        state_nxt = mispredict ? S_REDIR : S_IDLE;
      end
      S_REDIR: begin
        redirect_valid = 1'b1;
        flush          = 1'b1;
        state_nxt      = (FLUSH_CYCLES > 1) ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        flush = 1'b1;
        if (flush_cnt == '0)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture the operands and the prediction context on accept. Both hold until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_a      <= '0;
      cmp_b      <= '0;
      cmp_funct3 <= '0;
      cmp_jump   <= 1'b0;
      cmp_brun   <= 1'b0;
      pc_q       <= '0;
      target_q   <= '0;
      pred_q     <= 1'b0;
    end else if (accept) begin
      cmp_a      <= req_rs1;
      cmp_b      <= req_rs2;
      cmp_funct3 <= req_funct3;
      cmp_jump   <= req_jump;
      cmp_brun   <= req_brun;
      pc_q       <= req_pc;
      target_q   <= req_target;
      pred_q     <= req_pred_taken;
    end
  end

  // Sample the comparator at the end of CMP: resolve pulse, redirect PC and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resolve_valid      <= 1'b0;
      resolve_taken      <= 1'b0;
      resolve_mispredict <= 1'b0;
      redirect_pc        <= '0;
      branch_count       <= '0;
      mispredict_count   <= '0;
    end else begin
      resolve_valid      <= (state == S_CMP);
      resolve_taken      <= (state == S_CMP) && cmp_taken;
      resolve_mispredict <= (state == S_CMP) && mispredict;
      if (state == S_CMP) begin
        if (mispredict)
          redirect_pc <= cmp_taken ? target_q : (pc_q + XLEN'(4));
        if (branch_count != '1)
          branch_count <= branch_count + CNT_W'(1);
        if (mispredict && mispredict_count != '1)
          mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Purpose: randomized and directed stimulus for branch_resolve_ctrl, checked against a transaction-level model.
// Latency: every request is followed cycle by cycle through CMP, resolve and flush.
// Backpressure: requests are sometimes held valid through the busy period to probe the req_ready gating.
module tb_branch_resolve_ctrl;

  localparam int XLEN = 32;
  localparam int FC   = 2;

  typedef struct {
    logic [31:0] rs1, rs2, pc, target;
    logic [2:0]  f3;
    logic        jump, brun, pred;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic [31:0] req_rs1 = '0, req_rs2 = '0, req_pc = '0, req_target = '0;
  logic [2:0]  req_funct3 = '0;
  logic req_jump = 1'b0, req_brun = 1'b0, req_pred_taken = 1'b0;

  logic        req_ready, cmp_jump, cmp_brun, cmp_taken;
  logic [31:0] cmp_a, cmp_b, redirect_pc;
  logic [2:0]  cmp_funct3;
  logic        resolve_valid, resolve_taken, resolve_mispredict, redirect_valid, flush;
  logic [15:0] branch_count, mispredict_count;

  logic        req_ready2, cmp_jump2, cmp_brun2, cmp_taken2;
  logic [31:0] cmp_a2, cmp_b2, redirect_pc2;
  logic [2:0]  cmp_funct32;
  logic        resolve_valid2, resolve_taken2, resolve_mispredict2, redirect_valid2, flush2;
  logic [1:0]  branch_count2, mispredict_count2;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_bc = 0;
  int          exp_mc = 0;
  logic [31:0] exp_rpc = '0;
  txn_t        txns[200];

  always #5 clk = ~clk;

  // Behavioural model of the external branch comparator.
  function automatic logic ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] f3, input logic j, input logic un);
    if (j) return 1'b1;
    case (f3)
      3'b000:        return a == b;
      3'b001:        return a != b;
      3'b100, 3'b110: return un ? (a < b) : ($signed(a) < $signed(b));
      3'b101, 3'b111: return un ? (a >= b) : ($signed(a) >= $signed(b));
      default:       return 1'b0;
    endcase
  endfunction

  assign cmp_taken  = ref_cmp(cmp_a, cmp_b, cmp_funct3, cmp_jump, cmp_brun);
  assign cmp_taken2 = ref_cmp(cmp_a2, cmp_b2, cmp_funct32, cmp_jump2, cmp_brun2);

  branch_resolve_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_funct3(req_funct3), .req_jump(req_jump),
    .req_brun(req_brun), .req_pred_taken(req_pred_taken), .req_pc(req_pc), .req_target(req_target),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_funct3(cmp_funct3), .cmp_jump(cmp_jump), .cmp_brun(cmp_brun),
    .cmp_taken(cmp_taken), .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_mispredict(resolve_mispredict), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .branch_count(branch_count),
    .mispredict_count(mispredict_count));

  // Narrow-counter copy driven identically, used to observe saturation.
  branch_resolve_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_funct3(req_funct3), .req_jump(req_jump),
    .req_brun(req_brun), .req_pred_taken(req_pred_taken), .req_pc(req_pc), .req_target(req_target),
    .cmp_a(cmp_a2), .cmp_b(cmp_b2), .cmp_funct3(cmp_funct32), .cmp_jump(cmp_jump2), .cmp_brun(cmp_brun2),
    .cmp_taken(cmp_taken2), .resolve_valid(resolve_valid2), .resolve_taken(resolve_taken2),
    .resolve_mispredict(resolve_mispredict2), .redirect_valid(redirect_valid2),
    .redirect_pc(redirect_pc2), .flush(flush2), .branch_count(branch_count2),
    .mispredict_count(mispredict_count2));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input txn_t t, input logic v);
    req_valid      = v;
    req_rs1        = t.rs1;
    req_rs2        = t.rs2;
    req_funct3     = t.f3;
    req_jump       = t.jump;
    req_brun       = t.brun;
    req_pred_taken = t.pred;
    req_pc         = t.pc;
    req_target     = t.target;
  endtask

  function automatic txn_t mk(input logic [31:0] rs1, input logic [31:0] rs2, input logic [2:0] f3,
                              input logic jump, input logic brun, input logic pred,
                              input logic [31:0] pc, input logic [31:0] target);
    txn_t t;
    t.rs1 = rs1; t.rs2 = rs2; t.f3 = f3; t.jump = jump; t.brun = brun;
    t.pred = pred; t.pc = pc; t.target = target;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    logic [2:0] f3s[6];
    f3s = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    t.rs1    = $urandom();
    t.rs2    = ($urandom_range(0, 2) == 0) ? t.rs1 : $urandom();
    t.f3     = f3s[$urandom_range(0, 5)];
    t.jump   = ($urandom_range(0, 7) == 0);
    t.brun   = $urandom_range(0, 1);
    t.pred   = $urandom_range(0, 1);
    t.pc     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    t.target = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    return t;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Drive one request starting in a cycle where the controller should be idle, and follow it to completion.
  // When hold is set, the next request is presented during the busy period and must be ignored.
  task automatic run_txn(input txn_t t, input bit hold, input txn_t nxt);
    logic tk, mp;
    check("ready_before_accept", req_ready, 1);
    drive(t, 1'b1);
    @(negedge clk);
    drive(nxt, hold);
    check("cmp_ready", req_ready, 0);
    check("cmp_resolve_valid", resolve_valid, 0);
    check("cmp_flush", flush, 0);
    check("cmp_a", cmp_a, t.rs1);
    check("cmp_b", cmp_b, t.rs2);
    check("cmp_funct3", cmp_funct3, t.f3);
    check("cmp_jump", cmp_jump, t.jump);
    check("cmp_brun", cmp_brun, t.brun);
    @(negedge clk);
    tk = ref_cmp(t.rs1, t.rs2, t.f3, t.jump, t.brun);
    mp = tk ^ t.pred;
    exp_bc++;
    if (mp) begin
      exp_mc++;
      exp_rpc = tk ? t.target : t.pc + 32'd4;
    end
    check("resolve_valid", resolve_valid, 1);
    check("resolve_taken", resolve_taken, tk);
    check("resolve_mispredict", resolve_mispredict, mp);
    check("redirect_valid", redirect_valid, mp);
    check("resolve_flush", flush, mp);
    check("resolve_ready", req_ready, !mp);
    check("redirect_pc", redirect_pc, exp_rpc);
    check("branch_count", branch_count, exp_bc);
    check("mispredict_count", mispredict_count, exp_mc);
    check("sat_branch_count", branch_count2, sat3(exp_bc));
    check("sat_mispredict_count", mispredict_count2, sat3(exp_mc));
    if (mp) begin
      for (int k = 1; k < FC; k++) begin
        @(negedge clk);
        check("flush_hold", flush, 1);
        check("flush_ready", req_ready, 0);
        check("flush_redirect_valid", redirect_valid, 0);
        check("flush_resolve_valid", resolve_valid, 0);
        check("flush_redirect_pc", redirect_pc, exp_rpc);
      end
      @(negedge clk);
      check("post_flush_ready", req_ready, 1);
      check("post_flush_flush", flush, 0);
      check("post_flush_resolve_valid", resolve_valid, 0);
    end
  endtask

  task automatic clear_model();
    exp_bc  = 0;
    exp_mc  = 0;
    exp_rpc = '0;
  endtask

  initial begin
    txn_t beq, bne, bltu, jmp, none;
    beq  = mk(32'h10, 32'h10, 3'b000, 1'b0, 1'b0, 1'b1, 32'h40, 32'h80);
    bne  = mk(32'h10, 32'h20, 3'b001, 1'b0, 1'b0, 1'b0, 32'h200, 32'h100);
    bltu = mk(32'hFFFF_FFFF, 32'h1, 3'b100, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h500);
    jmp  = mk(32'h0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h1000, 32'h2000);
    none = mk(32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state.
    @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_resolve_valid", resolve_valid, 0);
    check("rst_flush", flush, 0);
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_cmp_a", cmp_a, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_branch_count", branch_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases: correct BEQ, BNE mispredict, wrapping BLTU, and a jump with the next request held.
    run_txn(beq, 1'b0, none);
    run_txn(bne, 1'b0, none);
    run_txn(bltu, 1'b0, none);
    check("bltu_wrap_pc", redirect_pc, 32'h0);
    run_txn(jmp, 1'b1, beq);
    run_txn(beq, 1'b0, none);

    // Reset while in FLUSH: outputs drop immediately, counters clear.
    drive(bne, 1'b1);
    @(negedge clk);
    drive(none, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_flush", flush, 1);
    rst = 1'b1;
    #1;
    check("rst_flush_async", flush, 0);
    check("rst_redirect_async", redirect_valid, 0);
    check("rst_ready_async", req_ready, 1);
    check("rst_bc_async", branch_count, 0);
    check("rst_mc_async", mispredict_count, 0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    run_txn(beq, 1'b0, none);

    // Reset while in CMP: the in-flight branch is never counted.
    drive(bne, 1'b1);
    @(negedge clk);
    drive(none, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_cmp_ready", req_ready, 1);
    @(negedge clk);
    check("rst_cmp_resolve_valid", resolve_valid, 0);
    check("rst_cmp_bc", branch_count, 0);
    clear_model();
    rst = 1'b0;
    run_txn(beq, 1'b0, none);

    // Saturation of the narrow counters after back-to-back mispredicts.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 5; i++)
      run_txn(bne, (i < 4), bne);
    check("sat_bc_final", branch_count2, 3);
    check("sat_mc_final", mispredict_count2, 3);
    check("wide_mc_final", mispredict_count, 5);

    // Random traffic with random holds and idle gaps.
    for (int i = 0; i < 200; i++)
      txns[i] = rand_txn();
    for (int i = 0; i < 200; i++) begin
      bit hold;
      hold = (i < 199) && ($urandom_range(0, 1) == 1);
      run_txn(txns[i], hold, (i < 199) ? txns[i + 1] : none);
      if (!hold) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check("gap_ready", req_ready, 1);
          check("gap_resolve_valid", resolve_valid, 0);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences the shared branch comparator for the RISC-V core: accepts one branch/jump request at a time, drives the comparator operands, and samples its branch_taken result.
- Checks the result against the fetch-stage prediction and issues a PC redirect plus a timed pipeline flush on mispredict.
- Keeps saturating branch and mispredict counters.
- Sits between the decode/execute stage and fetch.

Parameters:
- XLEN, 32, datapath and PC width.
- FLUSH_CYCLES, 2, cycles flush stays asserted per mispredict (legal >= 1).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  branch request valid.
- req_ready  out  1  controller can accept a request.
- req_rs1  in  XLEN  operand a.
- req_rs2  in  XLEN  operand b.
- req_funct3  in  3  branch funct3.
- req_jump  in  1  unconditional jump.
- req_brun  in  1  unsigned compare.
- req_pred_taken  in  1  fetch-stage prediction.
- req_pc  in  XLEN  PC of the branch.
- req_target  in  XLEN  taken target.
- cmp_a, cmp_b  out  XLEN  comparator operands (registered).
- cmp_funct3  out  3  comparator funct3.
- cmp_jump  out  1  comparator Jump.
- cmp_brun  out  1  comparator BrUn.
- cmp_taken  in  1  comparator branch_taken (combinational from cmp_* outputs).
- resolve_valid  out  1  one-cycle pulse per resolved branch.
- resolve_taken  out  1  actual outcome, qualified by resolve_valid.
- resolve_mispredict  out  1  outcome != prediction, qualified by resolve_valid.
- redirect_valid  out  1  one-cycle redirect strobe.
- redirect_pc  out  XLEN  corrected fetch PC.
- flush  out  1  squash younger instructions.
- branch_count  out  CNT_W  resolved branches, saturating.
- mispredict_count  out  CNT_W  mispredicts, saturating.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0 except req_ready = 1; cmp_* = 0; counters = 0.
- States:
  - IDLE: req_ready = 1.
  - CMP: one cycle.
  - REDIR: one cycle.
  - FLUSH: FLUSH_CYCLES-1 cycles, counted by an internal down-counter.
- Accept: req_valid & req_ready at a posedge.
  - Latch rs1/rs2/funct3/jump/brun into cmp_*.
  - Latch pc, target, pred_taken internally.
  - Go to CMP.
- req_ready is low in CMP, REDIR and FLUSH. req_valid while busy is ignored; the requester holds it.
- CMP: cmp_* are stable for the whole cycle; cmp_taken is sampled at the closing edge.
  - mispredict = cmp_taken XOR pred.
  - Next state: REDIR on mispredict, otherwise IDLE.
- Resolve outputs: registered, driven in the cycle after CMP.
  - resolve_valid = 1 for exactly one cycle.
  - resolve_taken and resolve_mispredict are valid in that cycle.
  - All three are 0 in every other cycle.
- Correct prediction: resolve pulse occurs in the IDLE cycle, so a new request can be accepted in that same cycle. Throughput is 1 branch per 2 cycles.
- Mispredict:
  - REDIR cycle: redirect_valid = 1 and flush = 1.
  - redirect_pc = target if taken, else pc + 4 (modulo 2^XLEN, wraps).
  - flush stays high for exactly FLUSH_CYCLES consecutive cycles, starting with REDIR.
  - FLUSH_CYCLES = 1 → REDIR goes straight to IDLE.
  - redirect_pc holds its value until the next redirect.
- Jumps use the same path: cmp_taken = 1, so pred_taken = 0 gives a redirect to target.
- Counters update on the resolve edge:
  - branch_count +1.
  - mispredict_count +1 on mispredict.
  - Both saturate at all-ones and never wrap.
- cmp_* hold their last accepted values until the next accept.
- Reset mid-operation (any state): flush, redirect_valid and resolve_valid drop immediately. The in-flight branch is discarded and not counted.

Test Plan:
- BEQ a=0x10, b=0x10, pred=1, accept at cycle 0 → cmp_a = cmp_b = 0x10 in cycle 1; cycle 2: resolve_valid=1, taken=1, mispredict=0, redirect_valid=0, req_ready=1; branch_count=1.
- BNE a=0x10, b=0x20, pred=0, target=0x100, FLUSH_CYCLES=2 → cycle 2: redirect_valid=1, redirect_pc=0x100; flush=1 in cycles 2-3; req_ready=0 in cycles 1-3 and 1 in cycle 4; mispredict_count=1.
- BLTU a=0xFFFFFFFF, b=1, brun=1, funct3=100, pred=1, pc=0xFFFFFFFC → resolve_taken=0, mispredict=1, redirect_pc=0x00000000 (wrap).
- Jump=1, pred=0, target=0x2000, followed by a second request held valid during the busy period → redirect to 0x2000; second request accepted only in the first cycle req_ready=1; no request lost or duplicated.
- rst pulsed during the FLUSH state → flush/redirect_valid are 0 in the same cycle; counters = 0; req_ready = 1; the next BEQ-equal request resolves normally.
- CNT_W=2, five back-to-back mispredicts → branch_count and mispredict_count saturate at 3 and stay there.
